// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if
// Bundles the frame sequencer's handshake and address signals into one interface.
// There are three groups of signals:
//   SPI side    : frame_ready, src_addr, res_wr_en, res_wr_addr,
//                 result_ready, result_ack
//   FFT side    : fft_load, fft_load_addr, fft_start, fft_done,
//                 fft_out_valid, fft_clear
//   status      : busy, error, overrun_cnt
// Modports:
//   master : the sequencer
//   slave  : the surrounding SPI RAM / FFT / host logic
interface fft_frame_sequencer_if #(
  parameter int AW    = 9,
  parameter int OVR_W = 8
);
  logic             frame_ready;
  logic [AW-1:0]    src_addr;
  logic             fft_load;
  logic [AW-1:0]    fft_load_addr;
  logic             fft_start;
  logic             fft_done;
  logic             fft_out_valid;
  logic             fft_clear;
  logic             res_wr_en;
  logic [AW-1:0]    res_wr_addr;
  logic             result_ready;
  logic             result_ack;
  logic             busy;
  logic             error;
  logic [OVR_W-1:0] overrun_cnt;

  modport master (
    input  frame_ready, fft_done, fft_out_valid, result_ack,
    output src_addr, fft_load, fft_load_addr, fft_start, fft_clear,
           res_wr_en, res_wr_addr, result_ready, busy, error, overrun_cnt
  );

  modport slave (
    output frame_ready, fft_done, fft_out_valid, result_ack,
    input  src_addr, fft_load, fft_load_addr, fft_start, fft_clear,
           res_wr_en, res_wr_addr, result_ready, busy, error, overrun_cnt
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Frame scheduler between the SPI sample RAM and the FFT controller.
// One rising edge of frame_ready runs one complete frame:
//   1. Stream N samples into the FFT, compensating for the RAM read latency.
//   2. Pulse fft_start.
//   3. Wait for fft_done, bounded by a timeout.
//   4. Write the N results back to the RAM.
//   5. Hold result_ready until the host acknowledges.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : fft_frame_sequencer_if.master
//           (SPI RAM, FFT and host handshakes, plus status)
module fft_frame_sequencer #(
  parameter int N       = 512,
  parameter int AW      = 9,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 65535,
  parameter int OVR_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_frame_sequencer_if.master bus
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_PROCESS,
    S_UNLOAD,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;

  logic             fr_q, fr_prev_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    iss_cnt_q;
  logic [CW-1:0]    ld_cnt_q;
  logic             dl_vld_q  [RD_LAT];
  logic [AW-1:0]    dl_addr_q [RD_LAT];
  logic [TW-1:0]    tmo_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    wr_cnt_q;
  logic             err_q;
  logic [OVR_W-1:0] ovr_q;

  logic trig;
  logic issue;
  logic load_w;
  logic start_frame;
  logic overrun;
  logic start_w, clear_w, wr_en_w, ready_w, expire_w;

  assign trig   = fr_q & ~fr_prev_q;
  assign issue  = (state_q == S_LOAD) && (iss_cnt_q < CW'(N));
  assign load_w = dl_vld_q[RD_LAT-1];

  // An acknowledge that lands together with a new trigger restarts
  // immediately, so that frame is neither lost nor counted as an overrun.
  assign start_frame = trig && ((state_q == S_IDLE) ||
                                ((state_q == S_HOLD) && bus.result_ack));
  assign overrun     = trig && (state_q != S_IDLE) &&
                       !((state_q == S_HOLD) && bus.result_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_w  = 1'b0;
    clear_w  = 1'b0;
    wr_en_w  = 1'b0;
    ready_w  = 1'b0;
    expire_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Leave once the N-th delayed load strobe has gone out.
        if (load_w && (ld_cnt_q == CW'(N - 1))) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        start_w = 1'b1;
        state_d = S_PROCESS;
      end
      S_PROCESS: begin
        // tmo_q counts the PROCESS cycles already spent, so expiry
        // happens on the TIMEOUT-th cycle in this state.
        if (bus.fft_done) begin
          state_d = S_UNLOAD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          expire_w = 1'b1;
          clear_w  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_UNLOAD: begin
        if (bus.fft_out_valid) begin
          wr_en_w = 1'b1;
          if (wr_cnt_q == CW'(N - 1)) begin
            clear_w = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        ready_w = 1'b1;
        if (bus.result_ack) state_d = trig ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr_q      <= 1'b0;
      fr_prev_q <= 1'b0;
      rd_ptr_q  <= '0;
      iss_cnt_q <= '0;
      ld_cnt_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_vld_q[i]  <= 1'b0;
        dl_addr_q[i] <= '0;
      end
      tmo_q     <= '0;
      wr_ptr_q  <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      ovr_q     <= '0;
    end else begin
      fr_q      <= bus.frame_ready;
      fr_prev_q <= fr_q;

      // Issue side: the pointer parks on N-1 after the last read.
      // The wider issue count decides termination, so pointer wrap never matters.
      if (start_frame) begin
        rd_ptr_q  <= '0;
        iss_cnt_q <= '0;
        ld_cnt_q  <= '0;
      end else begin
        if (issue) begin
          iss_cnt_q <= iss_cnt_q + CW'(1);
          if (iss_cnt_q != CW'(N - 1)) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (load_w) ld_cnt_q <= ld_cnt_q + CW'(1);
      end

      // Read-latency delay line: stage 0 captures the address being issued.
      dl_vld_q[0]  <= issue;
      dl_addr_q[0] <= rd_ptr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_addr_q[i] <= dl_addr_q[i-1];
      end

      if (state_q == S_LAUNCH) begin
        tmo_q <= '0;
      end else if (state_q == S_PROCESS) begin
        tmo_q <= tmo_q + TW'(1);
      end

      if ((state_q == S_PROCESS) && bus.fft_done) begin
        wr_ptr_q <= '0;
        wr_cnt_q <= '0;
      end else if (wr_en_w) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        wr_cnt_q <= wr_cnt_q + CW'(1);
      end

      if (expire_w) err_q <= 1'b1;

      if (overrun && (ovr_q != {OVR_W{1'b1}})) ovr_q <= ovr_q + OVR_W'(1);
    end
  end

  assign bus.src_addr      = rd_ptr_q;
  assign bus.fft_load      = load_w;
  assign bus.fft_load_addr = dl_addr_q[RD_LAT-1];
  assign bus.fft_start     = start_w;
  assign bus.fft_clear     = clear_w;
  assign bus.res_wr_en     = wr_en_w;
  assign bus.res_wr_addr   = wr_ptr_q;
  assign bus.result_ready  = ready_w;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.error         = err_q;
  assign bus.overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer
// Directed bench for fft_frame_sequencer.
// Expected FFT load addresses and result write addresses are queued when a
// frame is triggered or a result word is driven.
// A negedge monitor pops and compares them as the DUT emits strobes.
// A second small instance (N=16, RD_LAT=3) covers the deeper read latency.
module tb_fft_frame_sequencer;
  localparam int N     = 512;
  localparam int AW    = 9;
  localparam int RL    = 1;
  localparam int TMO   = 1000;
  localparam int OVR_W = 8;
  localparam int N3    = 16;
  localparam int AW3   = 4;
  localparam int RL3   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cnt = 0;
  int clear_cnt = 0;
  int start_cyc = 0;
  int clear_cyc = 0;
  int ld_q[$];
  int wr_q[$];

  fft_frame_sequencer_if #(.AW(AW),  .OVR_W(OVR_W)) bus ();
  fft_frame_sequencer_if #(.AW(AW3), .OVR_W(OVR_W)) b3 ();

  fft_frame_sequencer #(.N(N), .AW(AW), .RD_LAT(RL), .TIMEOUT(TMO), .OVR_W(OVR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  fft_frame_sequencer #(.N(N3), .AW(AW3), .RD_LAT(RL3), .TIMEOUT(50), .OVR_W(OVR_W)) dut3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fft_load) begin
      if (ld_q.size() == 0) chk("load_extra", 32'(bus.fft_load_addr), 32'hFFFF_FFFF);
      else chk("load_addr", 32'(bus.fft_load_addr), ld_q.pop_front());
    end
    if (bus.res_wr_en) begin
      if (wr_q.size() == 0) chk("wr_extra", 32'(bus.res_wr_addr), 32'hFFFF_FFFF);
      else chk("wr_addr", 32'(bus.res_wr_addr), wr_q.pop_front());
    end
    if (bus.fft_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (bus.fft_clear) begin
      clear_cnt <= clear_cnt + 1;
      clear_cyc <= cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fr();
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
  endtask

  task automatic push_loads();
    for (int a = 0; a < N; a++) ld_q.push_back(a);
  endtask

  task automatic wait_start();
    int k = 0;
    while (!bus.fft_start && k < N + RL + 10) begin
      step();
      k++;
    end
    chk("start_seen", bus.fft_start, 1);
  endtask

  task automatic unload(input bit toggle, input int dly);
    int pushed = 0;
    int i = 0;
    repeat (dly) step();
    bus.fft_done = 1'b1;
    step();
    step();
    while (pushed < N && i < 4 * N) begin
      bus.fft_out_valid = toggle ? ((i % 2) == 0) : 1'b1;
      if (bus.fft_out_valid) begin
        wr_q.push_back(pushed);
        pushed++;
      end
      step();
      i++;
    end
    bus.fft_out_valid = 1'b0;
    bus.fft_done      = 1'b0;
  endtask

  task automatic ack_frame();
    chk("hold_ready", bus.result_ready, 1);
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    chk("ack_ready_low", bus.result_ready, 0);
    chk("ack_idle", bus.busy, 0);
  endtask

  initial begin
    int cc;
    int k;
    bus.frame_ready = 0; bus.fft_done = 0; bus.fft_out_valid = 0; bus.result_ack = 0;
    b3.frame_ready  = 0; b3.fft_done  = 0; b3.fft_out_valid  = 0; b3.result_ack  = 0;

    // Reset state
    repeat (3) step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_src", bus.src_addr, 0);
    chk("rst_load", bus.fft_load, 0);
    chk("rst_start", bus.fft_start, 0);
    chk("rst_ready", bus.result_ready, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_ovr", bus.overrun_cnt, 0);
    reset = 1'b0;
    step();
    chk("idle_busy", bus.busy, 0);

    // Frame 1: exact load/start timing, done after 100 cycles, continuous unload
    pulse_fr();
    push_loads();
    for (int c = 1; c <= N + RL + 1; c++) begin
      step();
      chk("f1_src", bus.src_addr, (c - 1 < N) ? c - 1 : N - 1);
      chk("f1_load", bus.fft_load, (c > RL) && (c <= N + RL));
      chk("f1_start", bus.fft_start, c == N + RL + 1);
    end
    cc = clear_cnt;
    unload(1'b0, 100);
    chk("f1_clear_once", clear_cnt, cc + 1);
    chk("f1_start_once", start_cnt, 1);
    chk("f1_wr_drained", wr_q.size(), 0);
    chk("f1_hold_busy", bus.busy, 1);
    repeat (3) step();
    ack_frame();

    // Frame 2: overruns during LOAD, gapped unload, extra valid, ack+trig
    pulse_fr();
    push_loads();
    step();
    repeat (3) begin
      pulse_fr();
      step();
    end
    wait_start();
    chk("ovr3", bus.overrun_cnt, 3);
    cc = clear_cnt;
    unload(1'b1, 10);
    chk("f2_clear_once", clear_cnt, cc + 1);
    chk("f2_wr_drained", wr_q.size(), 0);
    bus.fft_out_valid = 1'b1;
    #1;
    chk("extra_valid_no_wr", bus.res_wr_en, 0);
    step();
    bus.fft_out_valid = 1'b0;
    pulse_fr();
    bus.result_ack = 1'b1;
    push_loads();
    step();
    bus.result_ack = 1'b0;
    chk("acktrig_busy", bus.busy, 1);
    chk("acktrig_src0", bus.src_addr, 0);
    chk("acktrig_ready", bus.result_ready, 0);
    chk("acktrig_ovr", bus.overrun_cnt, 3);

    // Frame 3: saturating overrun while waiting, then timeout
    wait_start();
    repeat (300) begin
      pulse_fr();
      step();
    end
    chk("ovr_sat", bus.overrun_cnt, 255);
    cc = clear_cnt;
    k = 0;
    while (clear_cnt == cc && k < 1200) begin
      step();
      k++;
    end
    chk("tmo_clear", clear_cnt, cc + 1);
    chk("tmo_latency", clear_cyc - start_cyc, TMO);
    chk("tmo_error", bus.error, 1);
    chk("tmo_idle", bus.busy, 0);

    // Frame 4: normal frame after an error
    pulse_fr();
    push_loads();
    wait_start();
    cc = clear_cnt;
    unload(1'b0, 5);
    chk("f4_clear_once", clear_cnt, cc + 1);
    chk("err_sticky", bus.error, 1);
    ack_frame();

    // Frame 5: reset in the middle of LOAD
    pulse_fr();
    push_loads();
    k = 0;
    while (bus.src_addr != AW'(200) && k < N) begin
      step();
      k++;
    end
    chk("mid_src200", bus.src_addr, 200);
    reset = 1'b1;
    #1;
    chk("mrst_src", bus.src_addr, 0);
    chk("mrst_load", bus.fft_load, 0);
    chk("mrst_load_addr", bus.fft_load_addr, 0);
    chk("mrst_start", bus.fft_start, 0);
    chk("mrst_clear", bus.fft_clear, 0);
    chk("mrst_wr", bus.res_wr_en, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_error", bus.error, 0);
    chk("mrst_ovr", bus.overrun_cnt, 0);
    ld_q.delete();
    step();
    step();
    reset = 1'b0;
    step();

    // Frame 6: fresh frame after reset
    pulse_fr();
    push_loads();
    step();
    chk("fresh_src0", bus.src_addr, 0);
    chk("fresh_busy", bus.busy, 1);
    wait_start();
    unload(1'b0, 2);
    ack_frame();

    // RD_LAT=3 instance: load strobe lags the read address by 3 cycles
    b3.frame_ready = 1'b1;
    step();
    b3.frame_ready = 1'b0;
    for (int c = 1; c <= N3 + RL3 + 1; c++) begin
      step();
      chk("rl3_src", b3.src_addr, (c - 1 < N3) ? c - 1 : N3 - 1);
      chk("rl3_load", b3.fft_load, (c > RL3) && (c <= N3 + RL3));
      if ((c > RL3) && (c <= N3 + RL3)) chk("rl3_addr", b3.fft_load_addr, c - 1 - RL3);
      chk("rl3_start", b3.fft_start, c == N3 + RL3 + 1);
    end

    chk("ld_q_empty", ld_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
